// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: queues frames, waits for bus idle,
// launches the lowest-ID frame and handles arbitration loss and retry.
module can_tx_scheduler #(
  parameter int NUM_MB    = 4,
  parameter int RETRY_MAX = 15,
  parameter int IDLE_BITS = 11,
  localparam int SW = $clog2(NUM_MB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              rx,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_sel,
  input  logic [10:0]       wr_id,
  input  logic [31:0]       wr_data,
  input  logic [NUM_MB-1:0] abort,
  output logic [NUM_MB-1:0] pending,
  output logic [NUM_MB-1:0] tx_ok,
  output logic [NUM_MB-1:0] tx_fail,
  output logic              active,
  output logic [SW-1:0]     active_sel,
  output logic              eng_send,
  output logic [10:0]       eng_address,
  output logic [31:0]       eng_data,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic              eng_arb_lost
);

  localparam int CW = $clog2(IDLE_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_SELECT,
    S_LAUNCH,
    S_BUSY
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
  logic [10:0]       id_q [NUM_MB];
  logic [10:0]       id_d [NUM_MB];
  logic [31:0]       data_q [NUM_MB];
  logic [31:0]       data_d [NUM_MB];
  logic [3:0]        retry_q [NUM_MB];
  logic [3:0]        retry_d [NUM_MB];
  logic [NUM_MB-1:0] pending_q, pending_d;
  logic [NUM_MB-1:0] tx_ok_q, tx_ok_d;
  logic [NUM_MB-1:0] tx_fail_q, tx_fail_d;
  logic              active_q, active_d;
  logic [SW-1:0]     active_sel_q, active_sel_d;
  logic              eng_send_q, eng_send_d;
  logic [10:0]       eng_address_q, eng_address_d;
  logic [31:0]       eng_data_q, eng_data_d;

  logic              sel_found;
  logic [SW-1:0]     sel_idx;
  logic [10:0]       sel_id;
  logic              lock_en;
  logic [SW-1:0]     lock_sel;
  logic [3:0]        retry_inc;

  // Strict compare keeps the lowest index on equal IDs.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && (!sel_found || id_q[i] < sel_id)) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
        sel_id    = id_q[i];
      end
    end
  end

  // The mailbox being picked in SELECT is already protected.
  assign lock_en  = active_q || (state_q == S_SELECT && sel_found);
  assign lock_sel = active_q ? active_sel_q : sel_idx;
  assign retry_inc = retry_q[active_sel_q] + 4'd1;

  always_comb begin
    id_d          = id_q;
    data_d        = data_q;
    retry_d       = retry_q;
    pending_d     = pending_q;
    tx_ok_d       = '0;
    tx_fail_d     = '0;
    state_d       = state_q;
    idle_cnt_d    = '0;
    active_d      = active_q;
    active_sel_d  = active_sel_q;
    eng_send_d    = eng_send_q;
    eng_address_d = eng_address_q;
    eng_data_d    = eng_data_q;

    for (int i = 0; i < NUM_MB; i++) begin
      if (abort[i] && !(lock_en && lock_sel == SW'(i)))
        pending_d[i] = 1'b0;
    end

    if (wr_en && !(lock_en && lock_sel == wr_sel)) begin
      id_d[wr_sel]      = wr_id;
      data_d[wr_sel]    = wr_data;
      retry_d[wr_sel]   = '0;
      pending_d[wr_sel] = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pending_q != '0)
          state_d = S_WAIT_BUS;
      end
      S_WAIT_BUS: begin
        idle_cnt_d = idle_cnt_q;
        if (pending_q == '0) begin
          state_d = S_IDLE;
        end else if (baud_tick) begin
          if (!rx)
            idle_cnt_d = '0;
          else if (idle_cnt_q == CW'(IDLE_BITS - 1))
            state_d = S_SELECT;
          else
            idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          eng_address_d = id_q[sel_idx];
          eng_data_d    = data_q[sel_idx];
          active_sel_d  = sel_idx;
          active_d      = 1'b1;
          eng_send_d    = 1'b1;
          state_d       = S_LAUNCH;
        end else begin
          active_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_LAUNCH: begin
        if (eng_busy) begin
          eng_send_d = 1'b0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (eng_done) begin
          pending_d[active_sel_q] = 1'b0;
          tx_ok_d[active_sel_q]   = 1'b1;
          retry_d[active_sel_q]   = '0;
          active_d                = 1'b0;
          state_d                 = S_IDLE;
        end else if (eng_arb_lost) begin
          active_d = 1'b0;
          state_d  = S_WAIT_BUS;
        end else if (!eng_busy) begin
          active_d = 1'b0;
          state_d  = S_IDLE;
          if (retry_inc == 4'(RETRY_MAX)) begin
            pending_d[active_sel_q] = 1'b0;
            tx_fail_d[active_sel_q] = 1'b1;
            retry_d[active_sel_q]   = '0;
          end else begin
            retry_d[active_sel_q] = retry_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idle_cnt_q    <= '0;
      pending_q     <= '0;
      tx_ok_q       <= '0;
      tx_fail_q     <= '0;
      active_q      <= 1'b0;
      active_sel_q  <= '0;
      eng_send_q    <= 1'b0;
      eng_address_q <= '0;
      eng_data_q    <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        id_q[i]    <= '0;
        data_q[i]  <= '0;
        retry_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      pending_q     <= pending_d;
      tx_ok_q       <= tx_ok_d;
      tx_fail_q     <= tx_fail_d;
      active_q      <= active_d;
      active_sel_q  <= active_sel_d;
      eng_send_q    <= eng_send_d;
      eng_address_q <= eng_address_d;
      eng_data_q    <= eng_data_d;
      for (int i = 0; i < NUM_MB; i++) begin
        id_q[i]    <= id_d[i];
        data_q[i]  <= data_d[i];
        retry_q[i] <= retry_d[i];
      end
    end
  end

  assign pending     = pending_q;
  assign tx_ok       = tx_ok_q;
  assign tx_fail     = tx_fail_q;
  assign active      = active_q;
  assign active_sel  = active_sel_q;
  assign eng_send    = eng_send_q;
  assign eng_address = eng_address_q;
  assign eng_data    = eng_data_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed scenarios plus randomized
// frames checked against a mailbox/priority model.
module tb_can_tx_scheduler;

  localparam int IDLE = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        baud_tick = 1'b0;
  logic        rx = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [10:0] wr_id = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  abort = '0;
  logic [3:0]  pending, tx_ok, tx_fail;
  logic        active;
  logic [1:0]  active_sel;
  logic        eng_send;
  logic [10:0] eng_address;
  logic [31:0] eng_data;
  logic        eng_busy = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_arb_lost = 1'b0;

  int checks = 0;
  int errors = 0;
  bit rx_pat [64];

  logic [10:0] m_id [4];
  logic [31:0] m_data [4];
  logic [3:0]  m_pend;

  always #5 clk = ~clk;

  can_tx_scheduler #(
    .NUM_MB(4), .RETRY_MAX(3), .IDLE_BITS(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_id(wr_id),
    .wr_data(wr_data), .abort(abort), .pending(pending),
    .tx_ok(tx_ok), .tx_fail(tx_fail), .active(active),
    .active_sel(active_sel), .eng_send(eng_send),
    .eng_address(eng_address), .eng_data(eng_data),
    .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_arb_lost(eng_arb_lost)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mb_write(input logic [1:0] s,
                          input logic [10:0] id,
                          input logic [31:0] d);
    wr_en = 1'b1; wr_sel = s; wr_id = id; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pat_ones(input int zero_at);
    for (int k = 0; k < 64; k++) rx_pat[k] = 1'b1;
    if (zero_at > 0) rx_pat[zero_at-1] = 1'b0;
  endtask

  // Tick number on which IDLE consecutive recessive bits complete.
  function automatic int exp_ticks();
    int run;
    run = 0;
    for (int k = 0; k < 64; k++) begin
      run = rx_pat[k] ? run + 1 : 0;
      if (run == IDLE) return k + 1;
    end
    return -1;
  endfunction

  // Ticks every other clock; returns tick count at which eng_send rose.
  task automatic run_idle(output int ticks);
    ticks = -1;
    step();
    for (int k = 0; k < 64; k++) begin
      baud_tick = 1'b1; rx = rx_pat[k];
      step();
      baud_tick = 1'b0; rx = 1'b1;
      step();
      if (eng_send === 1'b1) begin
        ticks = k + 1;
        break;
      end
    end
  endtask

  task automatic eng_accept();
    eng_busy = 1'b1;
    step();
  endtask

  task automatic eng_finish();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0; eng_busy = 1'b0;
  endtask

  task automatic eng_drop();
    eng_busy = 1'b0;
    step();
  endtask

  task automatic eng_lose();
    eng_arb_lost = 1'b1;
    step();
    eng_arb_lost = 1'b0; eng_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({pending, tx_ok, tx_fail} !== 12'h000) begin
      errors++;
      $display("FAIL reset_vec got %h exp 000",
               {pending, tx_ok, tx_fail});
    end
    checks++;
    if ({active, active_sel, eng_send} !== 4'h0) begin
      errors++;
      $display("FAIL reset_ctl got %h exp 0",
               {active, active_sel, eng_send});
    end
    checks++;
    if ({eng_address, eng_data} !== 43'h0) begin
      errors++;
      $display("FAIL reset_eng got %h exp 0",
               {eng_address, eng_data});
    end
  endtask

  task automatic test_single();
    int t;
    mb_write(2'd0, 11'h123, 32'hDEADBEEF);
    checks++;
    if (pending !== 4'b0001) begin
      errors++;
      $display("FAIL single_pend got %b exp 0001", pending);
    end
    pat_ones(0);
    run_idle(t);
    checks++;
    if (t !== exp_ticks()) begin
      errors++;
      $display("FAIL single_ticks got %0d exp %0d", t, exp_ticks());
    end
    checks++;
    if ({eng_address, eng_data} !== {11'h123, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_eng got %h %h exp 123 deadbeef",
               eng_address, eng_data);
    end
    checks++;
    if ({active, active_sel} !== 3'b100) begin
      errors++;
      $display("FAIL single_active got %b exp 100",
               {active, active_sel});
    end
    eng_accept();
    checks++;
    if (eng_send !== 1'b0) begin
      errors++;
      $display("FAIL single_send_drop got %b exp 0", eng_send);
    end
    eng_finish();
    checks++;
    if ({tx_ok, pending, active} !== 9'b0001_0000_0) begin
      errors++;
      $display("FAIL single_done got %b exp 000100000",
               {tx_ok, pending, active});
    end
    step();
    checks++;
    if (tx_ok !== 4'b0000) begin
      errors++;
      $display("FAIL single_okpulse got %b exp 0000", tx_ok);
    end
  endtask

  task automatic test_priority();
    int t;
    logic [1:0]  order [3];
    logic [10:0] ids [3];
    order[0] = 2'd2; order[1] = 2'd3; order[2] = 2'd1;
    ids[0] = 11'h050; ids[1] = 11'h050; ids[2] = 11'h200;
    mb_write(2'd1, 11'h200, 32'h1111_0001);
    mb_write(2'd2, 11'h050, 32'h2222_0002);
    mb_write(2'd3, 11'h050, 32'h3333_0003);
    pat_ones(0);
    for (int n = 0; n < 3; n++) begin
      run_idle(t);
      checks++;
      if (t !== IDLE) begin
        errors++;
        $display("FAIL prio_ticks%0d got %0d exp %0d", n, t, IDLE);
      end
      checks++;
      if ({active_sel, eng_address} !== {order[n], ids[n]}) begin
        errors++;
        $display("FAIL prio_sel%0d got %0d %h exp %0d %h", n,
                 active_sel, eng_address, order[n], ids[n]);
      end
      eng_accept();
      eng_finish();
      checks++;
      if (tx_ok !== 4'(1 << order[n])) begin
        errors++;
        $display("FAIL prio_ok%0d got %b exp %b", n, tx_ok,
                 4'(1 << order[n]));
      end
      step();
    end
  endtask

  task automatic test_idle_qual();
    int t;
    mb_write(2'd2, 11'h0F0, 32'hCAFE_0001);
    pat_ones(7);
    run_idle(t);
    checks++;
    if (t !== exp_ticks() || t !== 7 + IDLE) begin
      errors++;
      $display("FAIL idleq_ticks got %0d exp %0d", t, 7 + IDLE);
    end
    eng_accept();
    eng_finish();
    step();
  endtask

  task automatic test_arb_lost();
    int t;
    mb_write(2'd1, 11'h3A5, 32'h0BAD_F00D);
    pat_ones(0);
    run_idle(t);
    eng_accept();
    eng_lose();
    checks++;
    if ({active, pending, tx_ok, tx_fail} !== 13'b0_0010_0000_0000) begin
      errors++;
      $display("FAIL arb_state got %b exp 0001000000000",
               {active, pending, tx_ok, tx_fail});
    end
    run_idle(t);
    checks++;
    if (t !== IDLE) begin
      errors++;
      $display("FAIL arb_ticks got %0d exp %0d", t, IDLE);
    end
    checks++;
    if ({eng_address, eng_data} !== {11'h3A5, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL arb_relaunch got %h %h exp 3a5 0badf00d",
               eng_address, eng_data);
    end
    eng_accept();
    eng_finish();
    step();
  endtask

  // Error, arbitration loss, error, error: fail only on third error.
  task automatic test_retry();
    int t;
    mb_write(2'd0, 11'h0AA, 32'h5555_AAAA);
    pat_ones(0);
    for (int a = 0; a < 4; a++) begin
      run_idle(t);
      checks++;
      if (t !== IDLE) begin
        errors++;
        $display("FAIL retry_ticks%0d got %0d exp %0d", a, t, IDLE);
      end
      eng_accept();
      if (a == 1) begin
        eng_lose();
        checks++;
        if ({tx_fail, pending[0]} !== 5'b0000_1) begin
          errors++;
          $display("FAIL retry_arb got %b exp 00001",
                   {tx_fail, pending[0]});
        end
      end else begin
        eng_drop();
        checks++;
        if (a < 3 && {tx_fail, pending[0], active} !== 6'b0000_10)
        begin
          errors++;
          $display("FAIL retry_err%0d got %b exp 000010", a,
                   {tx_fail, pending[0], active});
        end else if (a == 3 &&
                     {tx_fail, pending[0], active} !== 6'b0001_00)
        begin
          errors++;
          $display("FAIL retry_fail got %b exp 000100",
                   {tx_fail, pending[0], active});
        end
        step();
        checks++;
        if ({tx_fail, eng_send} !== 5'b0) begin
          errors++;
          $display("FAIL retry_after%0d got %b exp 00000", a,
                   {tx_fail, eng_send});
        end
      end
    end
  endtask

  task automatic test_abort_write();
    int t;
    mb_write(2'd0, 11'h010, 32'hA0A0_A0A0);
    mb_write(2'd1, 11'h300, 32'hB1B1_B1B1);
    pat_ones(0);
    run_idle(t);
    eng_accept();
    abort = 4'b0001;
    step();
    abort = 4'b0000;
    checks++;
    if (pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_active got %b exp 1", pending[0]);
    end
    abort = 4'b0010;
    step();
    abort = 4'b0000;
    checks++;
    if (pending[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got %b exp 0", pending[1]);
    end
    abort = 4'b0100;
    mb_write(2'd2, 11'h222, 32'hC2C2_C2C2);
    abort = 4'b0000;
    checks++;
    if (pending[2] !== 1'b1) begin
      errors++;
      $display("FAIL abort_wrwins got %b exp 1", pending[2]);
    end
    mb_write(2'd0, 11'h7FF, 32'hFFFF_FFFF);
    checks++;
    if (eng_address !== 11'h010) begin
      errors++;
      $display("FAIL write_active got %h exp 010", eng_address);
    end
    eng_finish();
    checks++;
    if ({tx_ok, pending} !== 8'b0001_0100) begin
      errors++;
      $display("FAIL abort_done got %b exp 00010100",
               {tx_ok, pending});
    end
    step();
    run_idle(t);
    checks++;
    if ({eng_address, eng_data} !== {11'h222, 32'hC2C2_C2C2}) begin
      errors++;
      $display("FAIL abort_next got %h %h exp 222 c2c2c2c2",
               eng_address, eng_data);
    end
    eng_accept();
    eng_finish();
    step();
  endtask

  task automatic test_reset_busy();
    int t;
    mb_write(2'd3, 11'h155, 32'h1234_5678);
    pat_ones(0);
    run_idle(t);
    eng_accept();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pending, tx_ok, tx_fail, active, eng_send} !== 14'h0 ||
        {eng_address, eng_data} !== 43'h0) begin
      errors++;
      $display("FAIL rstbusy_now got %b %h exp 0 0",
               {pending, tx_ok, tx_fail, active, eng_send},
               {eng_address, eng_data});
    end
    eng_done = 1'b1;
    step();
    eng_done = 1'b0; eng_busy = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if ({pending, tx_ok, tx_fail, active, eng_send} !== 14'h0) begin
      errors++;
      $display("FAIL rstbusy_after got %b exp 0",
               {pending, tx_ok, tx_fail, active, eng_send});
    end
  endtask

  task automatic test_random();
    int t, nw, best;
    logic [1:0]  s;
    logic [10:0] id;
    logic [31:0] d;
    m_pend = '0;
    for (int r = 0; r < 10; r++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        s  = 2'($urandom_range(0, 3));
        id = $urandom_range(0, 1) ? 11'($urandom_range(0, 7))
                                  : 11'($urandom_range(0, 2047));
        d  = $urandom;
        mb_write(s, id, d);
        m_id[s] = id; m_data[s] = d; m_pend[s] = 1'b1;
      end
      best = -1;
      for (int i = 0; i < 4; i++)
        if (m_pend[i] && (best < 0 || m_id[i] < m_id[best]))
          best = i;
      for (int k = 0; k < 64; k++)
        rx_pat[k] = (k >= 24) || ($urandom_range(0, 5) != 0);
      run_idle(t);
      checks++;
      if (t !== exp_ticks()) begin
        errors++;
        $display("FAIL rnd_ticks%0d got %0d exp %0d", r, t,
                 exp_ticks());
      end
      checks++;
      if ({active_sel, eng_address, eng_data} !==
          {2'(best), m_id[best], m_data[best]}) begin
        errors++;
        $display("FAIL rnd_frame%0d got %0d %h %h exp %0d %h %h", r,
                 active_sel, eng_address, eng_data,
                 best, m_id[best], m_data[best]);
      end
      eng_accept();
      eng_finish();
      m_pend[best] = 1'b0;
      checks++;
      if ({tx_ok, pending} !== {4'(1 << best), m_pend}) begin
        errors++;
        $display("FAIL rnd_done%0d got %b exp %b", r,
                 {tx_ok, pending}, {4'(1 << best), m_pend});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_idle_qual();
    test_arb_lost();
    test_retry();
    test_abort_write();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
